// File: rtl/atm_pkg.sv
// ---------------------------------------------------------------------------
// atm_pkg
// Shared definitions for the ATM cash dispenser:
//   - disp_state_e : dispenser FSM states
//   - ERR_*        : err_code values reported to the controller
//   - DENOM_*      : note denominations; NOTE_RATIO = 100-notes per 1000-note
// ---------------------------------------------------------------------------
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FEED,
        ST_WAIT_ACK,
        ST_DONE,
        ST_ERR
    } disp_state_e;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_AMOUNT = 2'd1;
    localparam logic [1:0] ERR_STOCK  = 2'd2;
    localparam logic [1:0] ERR_JAM    = 2'd3;

    localparam int unsigned DENOM_100  = 100;
    localparam int unsigned DENOM_1000 = 1000;
    localparam int unsigned NOTE_RATIO = DENOM_1000 / DENOM_100;

endpackage

// File: rtl/cash_dispenser_if.sv
// ---------------------------------------------------------------------------
// cash_dispenser_if
// Bundles the controller request path, the refill path, the note-feed
// mechanism handshake and the status outputs of the cash dispenser.
//   master : controller / mechanism side (drives requests, refill, note_ack)
//   slave  : dispenser side (drives feed pulses, status, stock counters)
// ---------------------------------------------------------------------------
interface cash_dispenser_if #(
    parameter int B_WIDTH   = 20,
    parameter int CNT_WIDTH = 10
);
    logic                 dispense_req;
    logic [B_WIDTH-1:0]   amount;
    logic                 refill;
    logic [CNT_WIDTH-1:0] refill_1000;
    logic [CNT_WIDTH-1:0] refill_100;
    logic                 note_ack;
    logic                 note_1000_pulse;
    logic                 note_100_pulse;
    logic                 busy;
    logic                 dispense_done;
    logic                 dispense_error;
    logic [1:0]           err_code;
    logic [CNT_WIDTH-1:0] cnt_1000;
    logic [CNT_WIDTH-1:0] cnt_100;

    modport master (
        output dispense_req, amount, refill, refill_1000, refill_100, note_ack,
        input  note_1000_pulse, note_100_pulse, busy, dispense_done,
               dispense_error, err_code, cnt_1000, cnt_100
    );

    modport slave (
        input  dispense_req, amount, refill, refill_1000, refill_100, note_ack,
        output note_1000_pulse, note_100_pulse, busy, dispense_done,
               dispense_error, err_code, cnt_1000, cnt_100
    );
endinterface

// File: rtl/ack_watchdog.sv
// ---------------------------------------------------------------------------
// ack_watchdog
// Clear/enable counter that flags the cycle on which the count reaches
// THRESHOLD.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear (wins over en)
//   en       : count this cycle
//   timeout  : high while enabled on the cycle whose edge brings the count
//              to THRESHOLD, so exactly THRESHOLD enabled cycles elapse
//              before the owner reacts
// ---------------------------------------------------------------------------
module ack_watchdog #(
    parameter int unsigned THRESHOLD = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    localparam int unsigned W = $clog2(THRESHOLD + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != W'(THRESHOLD))) begin
            count <= count + W'(1);
        end
    end

    assign timeout = en && (count == W'(THRESHOLD - 1));

endmodule

// File: rtl/cash_dispenser.sv
// ---------------------------------------------------------------------------
// cash_dispenser
// Turns an approved withdrawal into single-note feed commands for a
// two-cassette mechanism (1000- and 100-unit notes), one note per
// note_ack handshake, and tracks cassette stock.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : cash_dispenser_if.slave
//              in : dispense_req, amount, refill, refill_1000, refill_100,
//                   note_ack
//              out: note_1000_pulse, note_100_pulse, busy, dispense_done,
//                   dispense_error, err_code, cnt_1000, cnt_100
// All outputs are registered.
// ---------------------------------------------------------------------------
module cash_dispenser
    import atm_pkg::*;
#(
    parameter int          B_WIDTH     = 20,
    parameter int          CNT_WIDTH   = 10,
    parameter int unsigned INIT_1000   = 500,
    parameter int unsigned INIT_100    = 1000,
    parameter int unsigned ACK_TIMEOUT = 1000
) (
    input logic             clk,
    input logic             rst,
    cash_dispenser_if.slave bus
);

    disp_state_e          state;
    logic [B_WIDTH-1:0]   amt_q;
    logic [CNT_WIDTH-1:0] rem_1000, rem_100;     // notes still to deliver
    logic [CNT_WIDTH-1:0] cnt_1000_q, cnt_100_q;
    logic                 p1000_q, p100_q, busy_q, done_q, error_q;
    logic [1:0]           err_q;

    // ---------------- planning (evaluated in CHECK) ----------------
    logic [B_WIDTH-1:0] k, k_tens, cnt1000_ext, n1000_w, n100_w;
    logic               amt_bad, short_100;

    always_comb begin
        k           = amt_q / B_WIDTH'(DENOM_100);
        k_tens      = k / B_WIDTH'(NOTE_RATIO);
        cnt1000_ext = B_WIDTH'(cnt_1000_q);
        // Prefer large notes, limited by what the 1000 cassette holds.
        n1000_w     = (k_tens < cnt1000_ext) ? k_tens : cnt1000_ext;
        n100_w      = k - B_WIDTH'(NOTE_RATIO) * n1000_w;
        amt_bad     = (amt_q == '0) || ((amt_q % B_WIDTH'(DENOM_100)) != '0);
        short_100   = n100_w > B_WIDTH'(cnt_100_q);
    end

    // ---------------- per-ack bookkeeping ----------------
    // All 1000-notes go first, so the note being acknowledged is a 1000
    // exactly when any remain in the plan.
    logic                 feeding_1000, last_note;
    logic [CNT_WIDTH-1:0] next_rem_1000, next_rem_100;

    always_comb begin
        feeding_1000  = rem_1000 != '0;
        next_rem_1000 = feeding_1000 ? rem_1000 - CNT_WIDTH'(1) : rem_1000;
        next_rem_100  = feeding_1000 ? rem_100 : rem_100 - CNT_WIDTH'(1);
        last_note     = (next_rem_1000 == '0) && (next_rem_100 == '0);
    end

    // ---------------- saturating refill ----------------
    logic [CNT_WIDTH:0]   sum_1000, sum_100;
    logic [CNT_WIDTH-1:0] sat_1000, sat_100;

    always_comb begin
        sum_1000 = {1'b0, cnt_1000_q} + {1'b0, bus.refill_1000};
        sum_100  = {1'b0, cnt_100_q}  + {1'b0, bus.refill_100};
        sat_1000 = sum_1000[CNT_WIDTH] ? '1 : sum_1000[CNT_WIDTH-1:0];
        sat_100  = sum_100[CNT_WIDTH]  ? '1 : sum_100[CNT_WIDTH-1:0];
    end

    // ---------------- ack watchdog ----------------
    logic wd_timeout;

    ack_watchdog #(.THRESHOLD(ACK_TIMEOUT)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == ST_FEED),
        .en      (state == ST_WAIT_ACK),
        .timeout (wd_timeout)
    );

    // ---------------- FSM with registered outputs ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            amt_q      <= '0;
            rem_1000   <= '0;
            rem_100    <= '0;
            cnt_1000_q <= CNT_WIDTH'(INIT_1000);
            cnt_100_q  <= CNT_WIDTH'(INIT_100);
            p1000_q    <= 1'b0;
            p100_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_q      <= ERR_NONE;
        end else begin
            // pulses are single-cycle unless re-armed below
            p1000_q <= 1'b0;
            p100_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.dispense_req) begin
                        amt_q  <= bus.amount;
                        err_q  <= ERR_NONE;
                        busy_q <= 1'b1;
                        state  <= ST_CHECK;
                    end else if (bus.refill) begin
                        cnt_1000_q <= sat_1000;
                        cnt_100_q  <= sat_100;
                    end
                end

                ST_CHECK: begin
                    if (amt_bad) begin
                        err_q   <= ERR_AMOUNT;
                        error_q <= 1'b1;
                        state   <= ST_ERR;
                    end else if (short_100) begin
                        err_q   <= ERR_STOCK;
                        error_q <= 1'b1;
                        state   <= ST_ERR;
                    end else begin
                        rem_1000 <= CNT_WIDTH'(n1000_w);
                        rem_100  <= CNT_WIDTH'(n100_w);
                        if (n1000_w != '0) p1000_q <= 1'b1;
                        else               p100_q  <= 1'b1;
                        state <= ST_FEED;
                    end
                end

                // Pulse is already on the output; ack here is ignored.
                ST_FEED: state <= ST_WAIT_ACK;

                ST_WAIT_ACK: begin
                    if (bus.note_ack) begin
                        if (feeding_1000) cnt_1000_q <= cnt_1000_q - CNT_WIDTH'(1);
                        else              cnt_100_q  <= cnt_100_q - CNT_WIDTH'(1);
                        rem_1000 <= next_rem_1000;
                        rem_100  <= next_rem_100;
                        if (last_note) begin
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            if (next_rem_1000 != '0) p1000_q <= 1'b1;
                            else                     p100_q  <= 1'b1;
                            state <= ST_FEED;
                        end
                    end else if (wd_timeout) begin
                        err_q   <= ERR_JAM;
                        error_q <= 1'b1;
                        state   <= ST_ERR;
                    end
                end

                ST_DONE, ST_ERR: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.note_1000_pulse = p1000_q;
    assign bus.note_100_pulse  = p100_q;
    assign bus.busy            = busy_q;
    assign bus.dispense_done   = done_q;
    assign bus.dispense_error  = error_q;
    assign bus.err_code        = err_q;
    assign bus.cnt_1000        = cnt_1000_q;
    assign bus.cnt_100         = cnt_100_q;

endmodule
